// File: rtl/pacman_fb_arbiter.sv
// Port-A arbiter for the 2 KB frame-buffer BRAM, shared by the TV80 CPU
// and the GPU fetcher. The GPU has priority, and a starvation guard bounds how long the CPU waits.
module pacman_fb_arbiter #(
    parameter logic [15:0] FB_BASE  = 16'h4000,
    parameter logic [15:0] FB_LAST  = 16'h47FF,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr_in,
    input  logic        cpu_mreq_n,
    input  logic        cpu_wr_n,
    input  logic [7:0]  cpu_data_in,
    output logic [7:0]  cpu_fb_data,
    output logic        cpu_fb_valid,
    output logic        cpu_wait_n,
    input  logic        gpu_req,
    input  logic [10:0] gpu_addr,
    output logic        gpu_grant,
    output logic        gpu_valid,
    output logic [7:0]  gpu_data,
    output logic        fb_ena,
    output logic        fb_wea,
    output logic [10:0] fb_addra,
    output logic [7:0]  fb_dina,
    input  logic [7:0]  fb_douta,
    output logic [15:0] stall_cycles
);

    localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] W_MAX = WCW'(MAX_WAIT);

    typedef enum logic {
        S_IDLE,
        S_CPU_DONE
    } state_t;

    state_t         r_state;
    logic [WCW-1:0] r_wait_cnt;
    logic           r_rd_first;
    logic [7:0]     r_cpu_data;
    logic           r_cpu_valid;
    logic           r_gpu_valid;
    logic [15:0]    r_stall;

    logic           w_in_win;
    logic           w_cpu_req;
    logic           w_cpu_win;
    logic           w_gpu_win;

    // Request decode and single-winner arbitration for this cycle
    always_comb begin
        w_in_win  = (cpu_addr_in >= FB_BASE) && (cpu_addr_in <= FB_LAST);
        w_cpu_req = ~reset & ~cpu_mreq_n & w_in_win
                  & (r_state == S_IDLE);
        w_cpu_win = w_cpu_req & (~gpu_req | (r_wait_cnt == W_MAX));
        w_gpu_win = ~reset & gpu_req & ~w_cpu_win;
    end

    // Port-A steering and CPU stall, all forced idle during reset
    always_comb begin
        fb_ena     = 1'b0;
        fb_wea     = 1'b0;
        fb_addra   = 11'h000;
        fb_dina    = 8'h00;
        gpu_grant  = w_gpu_win;
        cpu_wait_n = ~w_cpu_req;
        if (w_cpu_win) begin
            fb_ena   = 1'b1;
            fb_wea   = ~cpu_wr_n;
            fb_addra = cpu_addr_in[10:0];
            fb_dina  = cpu_data_in;
        end else if (w_gpu_win) begin
            fb_ena   = 1'b1;
            fb_addra = gpu_addr;
        end
    end

    // CPU access FSM: grant, hold result, wait for the CPU to end its cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_rd_first  <= 1'b0;
            r_cpu_data  <= 8'h00;
            r_cpu_valid <= 1'b0;
        end else begin
            r_rd_first <= 1'b0;
            if (r_rd_first) begin
                r_cpu_data <= fb_douta;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_cpu_win) begin
                        r_state     <= S_CPU_DONE;
                        r_wait_cnt  <= '0;
                        r_cpu_valid <= cpu_wr_n;
                        r_rd_first  <= cpu_wr_n;
                    end else if (w_cpu_req) begin
                        if (r_wait_cnt < W_MAX) begin
                            r_wait_cnt <= r_wait_cnt + WCW'(1);
                        end
                    end else begin
                        r_wait_cnt <= '0;
                    end
                end
                S_CPU_DONE: begin
                    r_wait_cnt <= '0;
                    if (cpu_mreq_n) begin
                        r_state     <= S_IDLE;
                        r_cpu_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // GPU read pipeline: data arrives one cycle after the grant
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gpu_valid <= 1'b0;
        end else begin
            r_gpu_valid <= w_gpu_win;
        end
    end

    // Saturating count of cycles the CPU spent stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall <= 16'h0000;
        end else if (~cpu_wait_n && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'h0001;
        end
    end

    // The first CPU_DONE cycle forwards BRAM output; later cycles hold the latch
    assign cpu_fb_data  = r_rd_first ? fb_douta : r_cpu_data;
    assign cpu_fb_valid = r_cpu_valid;
    assign gpu_valid    = r_gpu_valid;
    assign gpu_data     = r_gpu_valid ? fb_douta : 8'h00;
    assign stall_cycles = r_stall;

endmodule

// File: tb/tb_pacman_fb_arbiter.sv
// Bench for pacman_fb_arbiter: a BRAM model, a reference model,
// directed scenarios, then randomized traffic.
module tb_pacman_fb_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr_in;
    logic        cpu_mreq_n;
    logic        cpu_wr_n;
    logic [7:0]  cpu_data_in;
    logic [7:0]  cpu_fb_data;
    logic        cpu_fb_valid;
    logic        cpu_wait_n;
    logic        gpu_req;
    logic [10:0] gpu_addr;
    logic        gpu_grant;
    logic        gpu_valid;
    logic [7:0]  gpu_data;
    logic        fb_ena;
    logic        fb_wea;
    logic [10:0] fb_addra;
    logic [7:0]  fb_dina;
    logic [7:0]  fb_douta;
    logic [15:0] stall_cycles;

    logic [7:0]  bram    [2048];
    logic [7:0]  ref_mem [2048];
    logic        pre_we;
    logic [10:0] pre_a;
    logic [7:0]  pre_d;

    int n_checks = 0;
    int n_fail   = 0;

    int         m_phase;
    int         m_lost;
    logic       m_cv;
    logic [7:0] m_cd;
    logic       m_gv;
    logic [7:0] m_gd;
    int         m_stall;
    logic       last_gpu_go;

    pacman_fb_arbiter #(.MAX_WAIT(MAXW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_addr_in  (cpu_addr_in),
        .cpu_mreq_n   (cpu_mreq_n),
        .cpu_wr_n     (cpu_wr_n),
        .cpu_data_in  (cpu_data_in),
        .cpu_fb_data  (cpu_fb_data),
        .cpu_fb_valid (cpu_fb_valid),
        .cpu_wait_n   (cpu_wait_n),
        .gpu_req      (gpu_req),
        .gpu_addr     (gpu_addr),
        .gpu_grant    (gpu_grant),
        .gpu_valid    (gpu_valid),
        .gpu_data     (gpu_data),
        .fb_ena       (fb_ena),
        .fb_wea       (fb_wea),
        .fb_addra     (fb_addra),
        .fb_dina      (fb_dina),
        .fb_douta     (fb_douta),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) begin
            bram[pre_a] <= pre_d;
        end else if (fb_ena) begin
            if (fb_wea) bram[fb_addra] <= fb_dina;
            fb_douta <= bram[fb_addra];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        logic win, want, cpu_go, gpu_go, e_wn;
        logic [10:0] e_a;
        logic [7:0]  e_d;
        #4;
        win    = (cpu_addr_in >= 16'h4000) && (cpu_addr_in <= 16'h47FF);
        want   = !reset && !cpu_mreq_n && win && (m_phase == 0);
        cpu_go = want && (!gpu_req || (m_lost >= MAXW));
        gpu_go = !reset && gpu_req && !cpu_go;
        e_wn   = !want;
        e_a    = cpu_go ? cpu_addr_in[10:0] : (gpu_go ? gpu_addr : 11'h0);
        e_d    = cpu_go ? cpu_data_in : 8'h00;
        check("cpu_wait_n", {31'b0, cpu_wait_n}, {31'b0, e_wn});
        check("gpu_grant", {31'b0, gpu_grant}, {31'b0, gpu_go});
        check("fb_ena", {31'b0, fb_ena}, {31'b0, cpu_go | gpu_go});
        check("fb_wea", {31'b0, fb_wea}, {31'b0, cpu_go & ~cpu_wr_n});
        check("fb_addra", {21'b0, fb_addra}, {21'b0, e_a});
        check("fb_dina", {24'b0, fb_dina}, {24'b0, e_d});
        check("gpu_valid", {31'b0, gpu_valid}, {31'b0, m_gv});
        if (m_gv) check("gpu_data", {24'b0, gpu_data}, {24'b0, m_gd});
        check("cpu_fb_valid", {31'b0, cpu_fb_valid}, {31'b0, m_cv});
        check("cpu_fb_data", {24'b0, cpu_fb_data}, {24'b0, m_cd});
        check("stall_cycles", {16'b0, stall_cycles}, m_stall);
        last_gpu_go = gpu_go;
        if (reset) begin
            m_phase = 0; m_lost = 0; m_cv = 0;
            m_cd = 0; m_gv = 0; m_stall = 0;
        end else begin
            m_gv = gpu_go;
            if (gpu_go) m_gd = ref_mem[gpu_addr];
            if (!e_wn && m_stall < 65535) m_stall++;
            if (cpu_go) begin
                m_phase = 1;
                m_lost  = 0;
                m_cv    = cpu_wr_n;
                if (cpu_wr_n) m_cd = ref_mem[cpu_addr_in[10:0]];
                else ref_mem[cpu_addr_in[10:0]] = cpu_data_in;
            end else if (want) begin
                if (m_lost < MAXW) m_lost++;
            end else if (m_phase == 1) begin
                m_lost = 0;
                if (cpu_mreq_n) begin
                    m_phase = 0;
                    m_cv    = 0;
                end
            end else begin
                m_lost = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_set(input logic mreq_n, input logic [15:0] a,
                           input logic wr_n, input logic [7:0] d);
        cpu_mreq_n  = mreq_n;
        cpu_addr_in = a;
        cpu_wr_n    = wr_n;
        cpu_data_in = d;
    endtask

    initial begin
        int run;
        int sel;
        reset = 1'b1; pre_we = 1'b0; pre_a = 0; pre_d = 0;
        gpu_req = 1'b0; gpu_addr = 0; last_gpu_go = 1'b0;
        cpu_set(1'b1, 16'h0000, 1'b1, 8'h00);
        m_phase = 0; m_lost = 0; m_cv = 0; m_cd = 0;
        m_gv = 0; m_gd = 0; m_stall = 0;
        @(posedge clk);
        #1;
        cyc();
        cyc();

        for (int i = 0; i < 2048; i++) begin
            pre_we = 1'b1;
            pre_a  = 11'(i);
            pre_d  = (i == 16'h123) ? 8'hA5 : 8'($urandom);
            ref_mem[i] = pre_d;
            @(posedge clk);
            #1;
        end
        pre_we = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();

        cpu_set(1'b0, 16'h4123, 1'b1, 8'h00);
        cyc();
        cyc();
        check("lone_rd_data", {24'b0, cpu_fb_data}, 32'hA5);
        cyc();
        cyc();
        cpu_set(1'b1, 16'h4123, 1'b1, 8'h00);
        cyc();
        cyc();

        cpu_set(1'b0, 16'h47FF, 1'b0, 8'h3C);
        cyc();
        cyc();
        cpu_set(1'b1, 16'h47FF, 1'b1, 8'h00);
        cyc();
        cpu_set(1'b0, 16'h47FF, 1'b1, 8'h00);
        cyc();
        cyc();
        check("wr_readback", {24'b0, cpu_fb_data}, 32'h3C);
        cpu_set(1'b1, 16'h47FF, 1'b1, 8'h00);
        cyc();

        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cpu_set(1'b0, 16'h4200, 1'b1, 8'h00);
        gpu_req = 1'b1; gpu_addr = 11'h010;
        for (int i = 0; i < 9; i++) begin
            cyc();
            if (last_gpu_go) gpu_addr = gpu_addr + 11'h1;
        end
        cpu_set(1'b1, 16'h4200, 1'b1, 8'h00);
        cyc();
        check("starve_stall", {16'b0, stall_cycles}, 32'd5);
        gpu_req = 1'b0;
        cyc();

        for (int i = 0; i < 16; i++) begin
            gpu_req  = 1'b1;
            gpu_addr = 11'(i);
            cyc();
        end
        gpu_req = 1'b0;
        cyc();

        cpu_set(1'b0, 16'h4800, 1'b1, 8'h00);
        cyc(); cyc(); cyc();
        cpu_set(1'b0, 16'h3FFF, 1'b0, 8'h77);
        cyc(); cyc(); cyc();
        cpu_set(1'b1, 16'h3FFF, 1'b1, 8'h00);
        cyc();

        cpu_set(1'b0, 16'h4050, 1'b1, 8'h00);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        cpu_set(1'b1, 16'h4050, 1'b1, 8'h00);
        cyc();

        run = 0;
        for (int n = 0; n < 4000; n++) begin
            if (run == 0) begin
                run = $urandom_range(1, 6);
                sel = $urandom_range(0, 9);
                cpu_mreq_n  = 1'($urandom_range(0, 1));
                cpu_wr_n    = ($urandom_range(0, 2) != 0);
                cpu_data_in = 8'($urandom);
                if (sel == 0)      cpu_addr_in = 16'h3FFF;
                else if (sel == 1) cpu_addr_in = 16'h4800;
                else if (sel == 2) cpu_addr_in = 16'($urandom);
                else cpu_addr_in = 16'h4000 + 16'($urandom_range(0, 2047));
            end
            run--;
            if (!gpu_req || last_gpu_go) begin
                gpu_req  = ($urandom_range(0, 1) == 1);
                gpu_addr = 11'($urandom);
            end
            reset = ($urandom_range(0, 149) == 0);
            cyc();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
